equiv_stim_gen: RTL

Stimulus source for the dual-instance equivalence harness. Produces one five-field input vector per accepted handshake and drives the harness inputs `wire0`…`wire4`. Two modes:
- pseudo-random vectors from a 64-bit Galois LFSR;
- deterministic walking-one vectors across the packed 49-bit word.

Runs a programmable number of vectors per `start` pulse and signals completion, so campaigns are repeatable from a seed.

---
 rtl/equiv_stim_gen.sv | 87 ++++++++
 1 files changed

// File: rtl/equiv_stim_gen.sv
// equiv_stim_gen: LFSR or walking-one vector source for the equivalence harness
module equiv_stim_gen #(
   parameter logic [63:0] SEED = 64'h0000_0000_0000_0001,
   parameter logic [63:0] TAPS = 64'hD800_0000_0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode,
   input  logic [15:0]        num_vectors,
   input  logic               vec_ready,
   output logic               vec_valid,
   output logic [16:0]        wire0,
   output logic [8:0]         wire1,
   output logic [2:0]         wire2,
   output logic signed [13:0] wire3,
   output logic [5:0]         wire4,
   output logic [15:0]        vec_idx,
   output logic               busy,
   output logic               done
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   localparam logic [63:0] SEED_NZ = (SEED == 64'd0) ? 64'd1 : SEED;
   function automatic logic [63:0] step(input logic [63:0] v);
      return (v >> 1) ^ (v[0] ? TAPS : 64'd0);
   endfunction
   logic [1:0]  state;
   logic [63:0] s, s0, s1;
   logic [48:0] p;
   logic [15:0] rem;
   logic [5:0]  pos, pos_n;
   logic        m;
   always_comb begin
      s0 = step(SEED_NZ);
      s1 = step(s);
      pos_n = (pos == 6'd48) ? 6'd0 : pos + 6'd1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         s <= SEED_NZ;
         p <= '0;
         vec_idx <= '0;
         rem <= '0;
         pos <= '0;
         m <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               if (num_vectors == 16'd0) state <= DONE;
               else begin
                  state <= RUN;
                  m <= mode;
                  rem <= num_vectors;
                  s <= s0;
                  p <= mode ? 49'd1 : s0[63:15];
                  vec_idx <= '0;
                  pos <= '0;
               end
            end
            RUN: if (vec_ready) begin
               if (rem == 16'd1) state <= DONE;
               else begin
                  rem <= rem - 16'd1;
                  vec_idx <= vec_idx + 16'd1;
                  if (m) begin
                     pos <= pos_n;
                     p <= 49'd1 << pos_n;
                  end else begin
                     s <= s1;
                     p <= s1[63:15];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign vec_valid = state == RUN;
   assign busy = state == RUN;
   assign done = state == DONE;
   assign wire0 = p[48:32];
   assign wire1 = p[31:23];
   assign wire2 = p[22:20];
   assign wire3 = p[19:6];
   assign wire4 = p[5:0];
endmodule
